// File: rtl/logic_unit_pkg.sv
// Shared definitions for the two-input logic unit and its sequencer.
// Op encodings match the datapath's 4:1 mux select.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NOTA = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    localparam int N_OPS = 4;

    // First op of a run: a sweep always begins at AND.
    function automatic logic [1:0] first_op(
        input logic       sweep,
        input logic [1:0] step
    );
        return sweep ? 2'(OP_AND) : step;
    endfunction

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Board/datapath-facing signal bundle of the logic-op sequencer.
// master = sequencer side, slave = board and logic-unit side.
interface logic_op_sequencer_if;

    logic       btn;
    logic       sweep_mode;
    logic       op_in;
    logic [1:0] sel;
    logic [3:0] result;
    logic [1:0] last_op;
    logic       busy;
    logic       valid;

    modport master (
        input  btn,
        input  sweep_mode,
        input  op_in,
        output sel,
        output result,
        output last_op,
        output busy,
        output valid
    );

    modport slave (
        output btn,
        output sweep_mode,
        output op_in,
        input  sel,
        input  result,
        input  last_op,
        input  busy,
        input  valid
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// and a registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic start
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            start   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            start   <= level & ~level_d;
            // cnt counts agreeing cycles already seen; the Nth flips level
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_op_sequencer.sv
// Drives the logic unit's mux select and collects per-op results,
// one op per press (single-step) or all four per press (sweep).
module logic_op_sequencer
    import logic_unit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_op_sequencer_if.master bus
);

    logic       start;
    seq_state_e state;
    logic       sweep_q;
    logic [1:0] step_idx;
    logic [1:0] sel_q;
    logic [3:0] result_q;
    logic [1:0] last_op_q;
    logic       busy_q;
    logic       valid_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.btn),
        .start(start)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sweep_q   <= 1'b0;
            step_idx  <= 2'd0;
            sel_q     <= 2'(OP_AND);
            result_q  <= 4'b0000;
            last_op_q <= 2'd0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sweep_q <= bus.sweep_mode;
                        sel_q   <= first_op(bus.sweep_mode, step_idx);
                        busy_q  <= 1'b1;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    result_q[sel_q] <= bus.op_in;
                    last_op_q       <= sel_q;
                    if (sweep_q && sel_q != 2'(OP_NOTA)) begin
                        sel_q <= sel_q + 2'd1;
                        state <= SETTLE;
                    end else begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    // Sweeps leave the single-step position alone.
                    if (!sweep_q) begin
                        step_idx <= step_idx + 2'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel     = sel_q;
    assign bus.result  = result_q;
    assign bus.last_op = last_op_q;
    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Self-checking bench for logic_op_sequencer with a behavioural
// logic unit and a press-level reference model.
module tb_logic_op_sequencer;
    import logic_unit_pkg::*;

    localparam int DBN = 2;

    typedef struct {
        logic       a;
        logic       b;
        logic       sw;
        int         bounces;
        logic [3:0] res;
        logic [1:0] last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic b;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   rise_cnt = 0;
    logic busy_prev = 1'b0;

    logic [3:0] m_res;
    int         m_step;

    logic_op_sequencer_if bus();

    logic_op_sequencer #(
        .DEBOUNCE_CYCLES(DBN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic op_ref(input int k, input logic x, input logic y);
        case (k)
            0:       return x & y;
            1:       return x | y;
            2:       return x ^ y;
            default: return ~x;
        endcase
    endfunction

    always_comb bus.op_in = op_ref(int'(bus.sel), a, b);

    always @(negedge clk) begin
        if (bus.valid) valid_cnt <= valid_cnt + 1;
        if (bus.busy && !busy_prev) rise_cnt <= rise_cnt + 1;
        busy_prev <= bus.busy;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic pa, input logic pb, input logic psw,
                         input int bounces);
        logic [1:0] prev;
        logic [7:0] seq;
        logic [7:0] e_seq;
        logic [1:0] e_last;
        int nseq, lat, wait_n, v0, r0, e_n, e_lat;
        bit got;
        if (psw) begin
            for (int k = 0; k < N_OPS; k++) m_res[k] = op_ref(k, pa, pb);
            e_last = 2'd3; e_seq = 8'h1B; e_n = 4; e_lat = 8;
        end else begin
            m_res[m_step] = op_ref(m_step, pa, pb);
            e_last = 2'(m_step); e_seq = 8'(m_step); e_n = 1; e_lat = 2;
            m_step = (m_step + 1) % 4;
        end
        v0 = valid_cnt;
        r0 = rise_cnt;
        a = pa;
        b = pb;
        bus.sweep_mode = psw;
        repeat (bounces) begin
            bus.btn = 1'b1;
            @(negedge clk);
            bus.btn = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        bus.btn = 1'b1;
        got = 0;
        wait_n = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (bus.busy) begin got = 1; wait_n = i; end
        end
        chk("busy_rise", 32'(got), 1);
        if (got) begin
            if (bounces == 0) chk("btn_to_busy", wait_n, DBN + 4);
            prev = bus.sel;
            seq = 8'(bus.sel);
            nseq = 1;
            lat = 0;
            got = 0;
            for (int i = 1; i <= 20 && !got; i++) begin
                @(negedge clk);
                bus.sweep_mode = 1'($urandom);
                if (bus.sel !== prev) begin
                    seq = {seq[5:0], bus.sel};
                    nseq++;
                    prev = bus.sel;
                end
                if (bus.valid) begin got = 1; lat = i; end
            end
            chk("valid_seen", 32'(got), 1);
            chk("latency", lat, e_lat);
            chk("sel_count", nseq, e_n);
            chk("sel_order", seq, e_seq);
            chk("result", bus.result, m_res);
            chk("last_op", bus.last_op, e_last);
            @(negedge clk);
            chk("valid_width", bus.valid, 0);
            chk("busy_fall", bus.busy, 0);
        end
        bus.btn = 1'b0;
        repeat (DBN + 8) @(negedge clk);
        chk("one_valid", valid_cnt - v0, 1);
        chk("one_start", rise_cnt - r0, 1);
    endtask

    vec_t tbl[8];
    int   v0, r0;
    bit   got;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 5, 4'b0110, 2'd3};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 0, 4'b0111, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 0, 4'b0111, 2'd1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 0, 4'b0011, 2'd2};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 0, 4'b0011, 2'd3};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 0, 4'b0010, 2'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 0, 4'b1000, 2'd3};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 4'b1010, 2'd1};

        rst = 1'b1;
        a = 1'b0;
        b = 1'b0;
        bus.btn = 1'b0;
        bus.sweep_mode = 1'b0;
        m_res = 4'b0000;
        m_step = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sel", bus.sel, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_last_op", bus.last_op, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        repeat (50) begin
            @(negedge clk);
            chk("idle", {bus.sel, bus.result, bus.busy, bus.valid}, 0);
        end

        foreach (tbl[i]) begin
            press(tbl[i].a, tbl[i].b, tbl[i].sw, tbl[i].bounces);
            chk("tbl_result", bus.result, tbl[i].res);
            chk("tbl_last_op", bus.last_op, tbl[i].last);
        end

        // Second press lands mid-sweep and must be dropped.
        v0 = valid_cnt;
        r0 = rise_cnt;
        a = 1'b0;
        b = 1'b1;
        bus.sweep_mode = 1'b1;
        for (int k = 0; k < N_OPS; k++) m_res[k] = op_ref(k, 1'b0, 1'b1);
        bus.btn = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.busy;
        end
        chk("dbl_busy", 32'(got), 1);
        bus.btn = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn = 1'b1;
        repeat (DBN + 20) @(negedge clk);
        bus.btn = 1'b0;
        repeat (DBN + 8) @(negedge clk);
        chk("dbl_result", bus.result, 4'b1110);
        chk("dbl_one_valid", valid_cnt - v0, 1);
        chk("dbl_one_start", rise_cnt - r0, 1);

        // Reset in the 5th busy cycle of a sweep.
        v0 = valid_cnt;
        a = 1'b1;
        b = 1'b1;
        bus.sweep_mode = 1'b1;
        bus.btn = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.busy;
        end
        chk("rst_mid_busy", 32'(got), 1);
        repeat (4) @(negedge clk);
        chk("pre_rst_sel", bus.sel, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_sel", bus.sel, 0);
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_last_op", bus.last_op, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_valid", bus.valid, 0);
        bus.btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (DBN + 8) @(negedge clk);
        chk("rst_no_valid", valid_cnt - v0, 0);
        m_res = 4'b0000;
        m_step = 0;
        press(1'b1, 1'b0, 1'b1, 0);
        press(1'b1, 1'b1, 1'b0, 0);

        for (int n = 0; n < 16; n++) begin
            press(1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
